puntuacion_multijugador: RTL and testbench
==========================================

PUNTUACION_MULTIJUGADOR -- requirements
Module: puntuacion_multijugador

Interface
REQ-001 SHALL have parameter WIDTH, default 13: score width in bits per player.
REQ-002 SHALL have parameter PLAYERS, default 2, legal range 2..8: number of independent player accumulators.
REQ-003 SHALL have parameter JW, default $clog2(PLAYERS): player-index width.
REQ-004 SHALL have port clk  input  1: single clock; all state is updated on the rising edge.
REQ-005 SHALL have port standBy  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port iniciar  input  1: start-song strobe.
REQ-007 SHALL have port terminar  input  1: end-song strobe.
REQ-008 SHALL have port enable  input  1: hit strobe that adds puntuacionEntrada to the selected player.
REQ-009 SHALL have port fallo  input  1: miss strobe for the selected player.
REQ-010 SHALL have port jugador  input  JW: selected player index.
REQ-011 SHALL have port puntuacionEntrada  input  WIDTH: points for this hit.
REQ-012 SHALL have port puntuacionSalida  output  PLAYERS*WIDTH: packed scores; player p occupies bits [p*WIDTH +: WIDTH].
REQ-013 SHALL have port record  output  WIDTH: best final score since reset.
REQ-014 SHALL have port ganador  output  JW: index of the leading player.
REQ-015 SHALL have port desborde  output  PLAYERS: sticky per-player saturation flags.
REQ-016 SHALL have port estado  output  2: state encoding, ESPERA=0, JUGANDO=1, FIN=2.

Function
REQ-017 SHALL implement the FSM states ESPERA, JUGANDO and FIN.
REQ-018 ESPERA SHALL move to JUGANDO on iniciar.
REQ-019 JUGANDO SHALL move to FIN on terminar.
REQ-020 FIN SHALL move to JUGANDO on iniciar; this transition clears every score, combo counter and desborde bit, and leaves record unchanged.
REQ-021 The ESPERA to JUGANDO transition SHALL also clear every score, combo counter and desborde bit.
REQ-022 If iniciar and terminar are high in the same cycle, the FSM SHALL take the iniciar transition when in ESPERA or FIN, and the terminar transition when in JUGANDO.
REQ-023 enable and fallo SHALL be honoured only in JUGANDO; in ESPERA or FIN they SHALL have no effect.
REQ-024 A strobe with jugador >= PLAYERS SHALL be ignored.
REQ-025 On enable, score[jugador] SHALL become sat(score + mult*puntuacionEntrada) at the next edge (1-cycle latency, visible on puntuacionSalida).
REQ-026 The sum SHALL be computed in WIDTH+3 bits and SHALL saturate at 2^WIDTH-1.
REQ-027 When saturation occurs, desborde[jugador] SHALL be set and SHALL stay set until cleared by iniciar or standBy.
REQ-028 Each player SHALL have a 5-bit combo counter that increments on enable and stops at 31.
REQ-029 fallo SHALL clear the selected player's combo counter and SHALL leave the score unchanged.
REQ-030 When enable and fallo are high together for the same player, fallo SHALL win: points are added at x1 and the combo counter becomes 0.
REQ-031 ganador SHALL be registered (1-cycle latency after the scores change) and SHALL equal the index of the maximum score; on a tie it SHALL be the lowest index.
REQ-032 On the JUGANDO to FIN transition, record SHALL become max(record, max score), using the scores including any enable taken in the same cycle as terminar.
REQ-033 The scores of unselected players SHALL be unchanged in every cycle.

Reset
REQ-034 When standBy is high at a rising edge, estado SHALL become ESPERA and all scores, combo counters, desborde, record and ganador SHALL become 0.
REQ-035 standBy SHALL override iniciar, terminar, enable and fallo in the same cycle, including mid-song; record is lost.
REQ-036 The block SHALL have no asynchronous reset path.

Configuration
REQ-037 SHALL provide the macro COMBO_MULT_EN.
REQ-038 With COMBO_MULT_EN defined, mult SHALL be 1 + min(combo/8, 3), giving x1..x4, where combo is the value before the current hit.
REQ-039 With COMBO_MULT_EN undefined, mult SHALL be 1 and the combo counters SHALL not be synthesised; fallo then has no effect.

Verification
REQ-040 Scenario: standBy=1 for 2 cycles, then iniciar, then enable with jugador=0, entrada=10 -> score0=10 one cycle later, and ganador=0 one cycle after that.
REQ-041 Scenario: p0=10, p1=20 (jugador=1, entrada=20), then terminar -> estado=FIN, record=20, ganador=1; then iniciar -> scores 0, record still 20.
REQ-042 Scenario: WIDTH=13, score0=8180, enable with entrada=20 -> score0=8191, desborde[0]=1; a further enable leaves 8191.
REQ-043 Scenario (COMBO_MULT_EN): 8 hits of entrada=8 on p0 (=64), then a 9th hit -> score0=80 (x2); then enable+fallo together with entrada=8 -> score0=88 and combo=0.
REQ-044 Scenario: enable in ESPERA, enable with jugador=3 (PLAYERS=2), and standBy asserted mid-song with enable high -> no score change for the first two; the standBy case gives all outputs 0 and estado=ESPERA.
REQ-045 Scenario: a tie at score 40 for p0 and p1 -> ganador=0.

Source files
------------

// File: rtl/puntuacion_multijugador.sv
// Multi-player song scorekeeper: saturating per-player accumulators, registered leader and best final score.
// Build option: define COMBO_MULT_EN to add 5-bit per-player combo counters driving an x1..x4 hit multiplier.
module puntuacion_multijugador #(
  parameter int WIDTH   = 13,
  parameter int PLAYERS = 2,
  parameter int JW      = $clog2(PLAYERS)
) (
  input  logic                     clk,
  input  logic                     standBy,
  input  logic                     iniciar,
  input  logic                     terminar,
  input  logic                     enable,
  input  logic                     fallo,
  input  logic [JW-1:0]            jugador,
  input  logic [WIDTH-1:0]         puntuacionEntrada,
  output logic [PLAYERS*WIDTH-1:0] puntuacionSalida,
  output logic [WIDTH-1:0]         record,
  output logic [JW-1:0]            ganador,
  output logic [PLAYERS-1:0]       desborde,
  output logic [1:0]               estado
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JUGANDO = 2'd1,
    FIN     = 2'd2
  } estadoT;

  estadoT             estadoQ, estadoD;
  logic               clearAll;
  logic               jugando;
  logic [PLAYERS-1:0] sel;
  logic [2:0]         mult;
  logic [WIDTH-1:0]   score  [PLAYERS];
  logic [WIDTH-1:0]   scoreD [PLAYERS];
  logic [PLAYERS-1:0] desbQ, desbD;
  logic [WIDTH-1:0]   recordQ, maxNext;
  logic [JW-1:0]      ganadorQ, lider;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    estadoD  = estadoQ;
    clearAll = 1'b0;
    case (estadoQ)
      ESPERA, FIN: if (iniciar) begin
        estadoD  = JUGANDO;
        clearAll = 1'b1;
      end
      JUGANDO: if (terminar) estadoD = FIN;
      default: estadoD = ESPERA;
    endcase
  end

  assign jugando = (estadoQ == JUGANDO);

  // Out-of-range indices simply match no player, so their strobes are dropped.
  always_comb begin
    sel = '0;
    for (int p = 0; p < PLAYERS; p++) sel[p] = ({1'b0, jugador} == (JW+1)'(p));
  end

`ifdef COMBO_MULT_EN
  logic [4:0] combo [PLAYERS];
  logic [4:0] comboSel;

  // Multiplier uses the combo before this hit; a simultaneous miss forces x1.
  always_comb begin
    comboSel = '0;
    for (int p = 0; p < PLAYERS; p++) if (sel[p]) comboSel = combo[p];
    mult = fallo ? 3'd1 : 3'd1 + {1'b0, comboSel[4:3]};
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PLAYERS; p++) begin
      if (standBy || clearAll) begin
        combo[p] <= '0;
      end else if (jugando && sel[p]) begin
        if (fallo)                             combo[p] <= '0;
        else if (enable && combo[p] != 5'd31)  combo[p] <= combo[p] + 5'd1;
      end
    end
  end
`else
  // Without combo counters a miss carries no information.
  logic unusedFallo;
  assign unusedFallo = fallo;
  assign mult        = 3'd1;
`endif

  // Next scores, with three guard bits so any overflow of the WIDTH-bit range is visible.
  always_comb begin
    logic [WIDTH+2:0] suma;
    suma    = '0;
    maxNext = '0;
    desbD   = desbQ;
    for (int p = 0; p < PLAYERS; p++) begin
      scoreD[p] = score[p];
      suma      = {3'b000, score[p]} + ({3'b000, puntuacionEntrada} * (WIDTH+3)'(mult));
      if (clearAll) begin
        scoreD[p] = '0;
        desbD[p]  = 1'b0;
      end else if (jugando && enable && sel[p]) begin
        if (|suma[WIDTH+2:WIDTH]) begin
          scoreD[p] = '1;
          desbD[p]  = 1'b1;
        end else begin
          scoreD[p] = suma[WIDTH-1:0];
        end
      end
      if (scoreD[p] > maxNext) maxNext = scoreD[p];
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    logic [WIDTH-1:0] best;
    best  = score[0];
    lider = '0;
    for (int p = 1; p < PLAYERS; p++) begin
      if (score[p] > best) begin
        best  = score[p];
        lider = JW'(p);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (standBy) begin
      estadoQ  <= ESPERA;
      desbQ    <= '0;
      recordQ  <= '0;
      ganadorQ <= '0;
      // NOTE: the score array is a bank of flops, not a RAM, so resetting every entry is legitimate.
      for (int p = 0; p < PLAYERS; p++) score[p] <= '0;
    end else begin
      estadoQ  <= estadoD;
      desbQ    <= desbD;
      ganadorQ <= lider;
      for (int p = 0; p < PLAYERS; p++) score[p] <= scoreD[p];
      if (jugando && terminar && (maxNext > recordQ)) recordQ <= maxNext;
    end
  end

  always_comb begin
    puntuacionSalida = '0;
    for (int p = 0; p < PLAYERS; p++) puntuacionSalida[p*WIDTH +: WIDTH] = score[p];
  end

  assign record   = recordQ;
  assign ganador  = ganadorQ;
  assign desborde = desbQ;
  assign estado   = estadoQ;

endmodule

// File: tb/tb_puntuacion_multijugador.sv
// Self-checking bench for puntuacion_multijugador: behavioural model feeding a scoreboard queue plus scenario constants.
// JW is widened to 2 so that an out-of-range player index (3 with PLAYERS=2) can be driven.
module tb_puntuacion_multijugador;
  localparam int WIDTH   = 13;
  localparam int PLAYERS = 2;
  localparam int JW      = 2;
  localparam int MAXS    = (1 << WIDTH) - 1;

  logic                     clk = 1'b0;
  logic                     standBy = 1'b0, iniciar = 1'b0, terminar = 1'b0, enable = 1'b0, fallo = 1'b0;
  logic [JW-1:0]            jugador = '0;
  logic [WIDTH-1:0]         puntuacionEntrada = '0;
  logic [PLAYERS*WIDTH-1:0] puntuacionSalida;
  logic [WIDTH-1:0]         record;
  logic [JW-1:0]            ganador;
  logic [PLAYERS-1:0]       desborde;
  logic [1:0]               estado;

  puntuacion_multijugador #(.WIDTH(WIDTH), .PLAYERS(PLAYERS), .JW(JW)) dut (
    .clk(clk), .standBy(standBy), .iniciar(iniciar), .terminar(terminar),
    .enable(enable), .fallo(fallo), .jugador(jugador), .puntuacionEntrada(puntuacionEntrada),
    .puntuacionSalida(puntuacionSalida), .record(record), .ganador(ganador),
    .desborde(desborde), .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]         est;
    logic [WIDTH-1:0]   s0, s1, rec;
    logic [JW-1:0]      gan;
    logic [PLAYERS-1:0] desb;
  } snapT;

  typedef struct packed {
    logic rst, ini, ter, en, fal;
    logic [JW-1:0]    jug;
    logic [WIDTH-1:0] pts;
  } stimT;

  int   compared = 0, mismatched = 0;
  snapT sbq[$];

  int mState = 0, mRecord = 0, mGan = 0;
  int mScore [PLAYERS] = '{default: 0};
  logic [PLAYERS-1:0] mDesb = '0;
`ifdef COMBO_MULT_EN
  int mCombo [PLAYERS] = '{default: 0};
`endif

  function automatic stimT st(input logic rst, ini, ter, en, fal, input int jug, input int pts);
    return {rst, ini, ter, en, fal, JW'(jug), WIDTH'(pts)};
  endfunction

  function automatic snapT snap();
    return {estado, puntuacionSalida[WIDTH-1:0], puntuacionSalida[2*WIDTH-1:WIDTH], record, ganador, desborde};
  endfunction

  // Reference behaviour, one call per clock edge; pushes the expected post-edge outputs.
  task automatic model_step(input stimT s);
    int   best, bestIdx, v, mult, top;
    snapT e;
    if (s.rst) begin
      mState = 0; mRecord = 0; mGan = 0; mDesb = '0;
      for (int p = 0; p < PLAYERS; p++) mScore[p] = 0;
`ifdef COMBO_MULT_EN
      for (int p = 0; p < PLAYERS; p++) mCombo[p] = 0;
`endif
    end else begin
      best = mScore[0]; bestIdx = 0;
      for (int p = 1; p < PLAYERS; p++) if (mScore[p] > best) begin best = mScore[p]; bestIdx = p; end
      if (mState != 1 && s.ini) begin
        mState = 1; mDesb = '0;
        for (int p = 0; p < PLAYERS; p++) mScore[p] = 0;
`ifdef COMBO_MULT_EN
        for (int p = 0; p < PLAYERS; p++) mCombo[p] = 0;
`endif
      end else if (mState == 1) begin
        if (s.jug < PLAYERS) begin
          if (s.en) begin
            mult = 1;
`ifdef COMBO_MULT_EN
            if (!s.fal) mult = 1 + ((mCombo[s.jug] / 8 > 3) ? 3 : mCombo[s.jug] / 8);
`endif
            v = mScore[s.jug] + mult * int'(s.pts);
            if (v > MAXS) begin v = MAXS; mDesb[s.jug] = 1'b1; end
            mScore[s.jug] = v;
          end
`ifdef COMBO_MULT_EN
          if (s.fal) mCombo[s.jug] = 0;
          else if (s.en && mCombo[s.jug] < 31) mCombo[s.jug] = mCombo[s.jug] + 1;
`endif
        end
        if (s.ter) begin
          top = 0;
          for (int p = 0; p < PLAYERS; p++) if (mScore[p] > top) top = mScore[p];
          if (top > mRecord) mRecord = top;
          mState = 2;
        end
      end
      mGan = bestIdx;
    end
    e = {2'(mState), WIDTH'(mScore[0]), WIDTH'(mScore[1]), WIDTH'(mRecord), JW'(mGan), mDesb};
    sbq.push_back(e);
  endtask

  task automatic drive(input stimT s);
    standBy = s.rst; iniciar = s.ini; terminar = s.ter; enable = s.en; fallo = s.fal;
    jugador = s.jug; puntuacionEntrada = s.pts;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(1,0,0,0,0,0,0));
    q.push_back(st(1,1,1,1,1,0,5));
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL reset step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 1) begin compared++; if (obs !== '0) begin mismatched++; $display("FAIL reset_all_zero: got %h, expected 0", obs); end end
    end
  endtask

  task automatic test_hit_and_end();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(0,1,0,0,0,0,0));   // start
    q.push_back(st(0,0,0,1,0,0,10));  // p0 += 10
    q.push_back(st(0,0,0,0,0,0,0));
    q.push_back(st(0,0,0,1,0,1,20));  // p1 += 20
    q.push_back(st(0,0,0,0,0,0,0));
    q.push_back(st(0,0,1,0,0,0,0));   // end song
    q.push_back(st(0,0,0,1,0,0,5));   // hit in FIN is ignored
    q.push_back(st(0,1,0,0,0,0,0));   // restart
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL hit step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 1) begin compared++; if (obs.s0 !== 13'd10) begin mismatched++; $display("FAIL first_hit_score: got %0d, expected 10", obs.s0); end end
      if (i == 4) begin compared++; if (obs.gan !== 2'd1) begin mismatched++; $display("FAIL leader_p1: got %0d, expected 1", obs.gan); end end
      if (i == 5) begin compared++; if (obs.est !== 2'd2 || obs.rec !== 13'd20) begin mismatched++; $display("FAIL end_song: got est=%0d rec=%0d, expected est=2 rec=20", obs.est, obs.rec); end end
      if (i == 6) begin compared++; if (obs.s0 !== 13'd10) begin mismatched++; $display("FAIL hit_in_fin: got %0d, expected 10", obs.s0); end end
      if (i == 7) begin compared++; if (obs.s0 !== 13'd0 || obs.s1 !== 13'd0 || obs.rec !== 13'd20) begin mismatched++; $display("FAIL restart: got s0=%0d s1=%0d rec=%0d, expected 0 0 20", obs.s0, obs.s1, obs.rec); end end
    end
  endtask

  task automatic test_saturation();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(0,0,0,1,0,0,8000));
    q.push_back(st(0,0,0,1,0,0,180));
    q.push_back(st(0,0,0,1,0,0,20));
    q.push_back(st(0,0,0,1,0,0,20));
    q.push_back(st(0,0,0,0,1,0,0));
    q.push_back(st(0,0,1,0,0,0,0));
    q.push_back(st(0,1,0,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL sat step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 1) begin compared++; if (obs.s0 !== 13'd8180) begin mismatched++; $display("FAIL pre_sat: got %0d, expected 8180", obs.s0); end end
      if (i == 2 || i == 3) begin compared++; if (obs.s0 !== 13'd8191 || obs.desb !== 2'b01) begin mismatched++; $display("FAIL saturate: got s0=%0d desb=%b, expected 8191 01", obs.s0, obs.desb); end end
      if (i == 6) begin compared++; if (obs.desb !== 2'b00 || obs.rec !== 13'd8191) begin mismatched++; $display("FAIL desb_clear: got desb=%b rec=%0d, expected 00 8191", obs.desb, obs.rec); end end
    end
  endtask

  task automatic test_ignored_and_midsong_reset();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(1,0,0,0,0,0,0));
    q.push_back(st(0,0,0,1,0,0,5));   // hit while waiting
    q.push_back(st(0,1,0,0,0,0,0));
    q.push_back(st(0,0,0,1,0,3,7));   // player index out of range
    q.push_back(st(0,0,0,1,0,1,5));
    q.push_back(st(0,0,1,0,0,0,0));
    q.push_back(st(0,1,0,0,0,0,0));
    q.push_back(st(0,0,0,1,0,1,9));
    q.push_back(st(1,1,0,1,0,1,9));   // standBy wins mid-song
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL ignore step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 1 || i == 3) begin compared++; if (obs.s0 !== 13'd0 || obs.s1 !== 13'd0) begin mismatched++; $display("FAIL ignored_hit: got s0=%0d s1=%0d, expected 0 0", obs.s0, obs.s1); end end
      if (i == 7) begin compared++; if (obs.s1 !== 13'd9 || obs.rec !== 13'd5) begin mismatched++; $display("FAIL pre_reset: got s1=%0d rec=%0d, expected 9 5", obs.s1, obs.rec); end end
      if (i == 8) begin compared++; if (obs !== '0) begin mismatched++; $display("FAIL midsong_reset: got %h, expected 0", obs); end end
    end
  endtask

  task automatic test_tie_and_end_hit();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(0,1,0,0,0,0,0));
    q.push_back(st(0,0,0,1,0,1,40));
    q.push_back(st(0,0,0,1,0,0,40));
    q.push_back(st(0,0,0,0,0,0,0));
    q.push_back(st(0,0,1,1,0,0,8));   // hit in the same cycle as terminar
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL tie step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 2) begin compared++; if (obs.gan !== 2'd1) begin mismatched++; $display("FAIL lead_before_tie: got %0d, expected 1", obs.gan); end end
      if (i == 3) begin compared++; if (obs.gan !== 2'd0) begin mismatched++; $display("FAIL tie_lowest: got %0d, expected 0", obs.gan); end end
      if (i == 4) begin compared++; if (obs.rec !== 13'd48 || obs.est !== 2'd2) begin mismatched++; $display("FAIL record_same_cycle: got rec=%0d est=%0d, expected 48 2", obs.rec, obs.est); end end
    end
  endtask

  task automatic test_combo();
    stimT q[$];
    snapT obs, e;
    q.push_back(st(0,1,0,0,0,0,0));
`ifdef COMBO_MULT_EN
    for (int k = 0; k < 8; k++) q.push_back(st(0,0,0,1,0,0,8));
    q.push_back(st(0,0,0,1,0,0,8));   // x2
    q.push_back(st(0,0,0,1,1,0,8));   // miss wins, x1
    q.push_back(st(0,0,0,1,0,0,8));   // combo restarted, x1
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL combo step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 8)  begin compared++; if (obs.s0 !== 13'd64) begin mismatched++; $display("FAIL combo_x1: got %0d, expected 64", obs.s0); end end
      if (i == 9)  begin compared++; if (obs.s0 !== 13'd80) begin mismatched++; $display("FAIL combo_x2: got %0d, expected 80", obs.s0); end end
      if (i == 10) begin compared++; if (obs.s0 !== 13'd88) begin mismatched++; $display("FAIL combo_fallo: got %0d, expected 88", obs.s0); end end
      if (i == 11) begin compared++; if (obs.s0 !== 13'd96) begin mismatched++; $display("FAIL combo_cleared: got %0d, expected 96", obs.s0); end end
    end
`else
    q.push_back(st(0,0,0,1,0,0,8));
    q.push_back(st(0,0,0,0,1,0,0));   // miss alone
    q.push_back(st(0,0,0,1,1,0,8));   // miss with hit
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL fallo step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
      if (i == 2) begin compared++; if (obs.s0 !== 13'd8) begin mismatched++; $display("FAIL fallo_alone: got %0d, expected 8", obs.s0); end end
      if (i == 3) begin compared++; if (obs.s0 !== 13'd16) begin mismatched++; $display("FAIL fallo_with_hit: got %0d, expected 16", obs.s0); end end
    end
`endif
  endtask

  task automatic test_back_to_back();
    stimT q[$];
    snapT obs, e;
    int   pts;
    for (int k = 0; k < 400; k++) begin
      pts = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAXS) : $urandom_range(0, 50);
      q.push_back(st($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 3), pts));
    end
    foreach (q[i]) begin
      drive(q[i]); obs = snap(); e = sbq.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL b2b step %0d: got est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b, expected est=%0d s0=%0d s1=%0d rec=%0d gan=%0d desb=%b", i, obs.est, obs.s0, obs.s1, obs.rec, obs.gan, obs.desb, e.est, e.s0, e.s1, e.rec, e.gan, e.desb); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hit_and_end();
    test_saturation();
    test_ignored_and_midsong_reset();
    test_tie_and_end_hit();
    test_combo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
